// File: rtl/avalon_mem_model.sv
`default_nettype none
// ============================================================================
// Module      : avalon_mem_model
// Description : Avalon-MM slave memory model with configurable wait states,
//               pipelined in-order read returns and an outstanding-read limit.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_mem_model #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 16,
    parameter int    WAIT_CYCLES  = 1,
    parameter int    READ_LATENCY = 2,
    parameter int    MAX_PENDING  = 4,
    parameter string INIT_FILE    = ""
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic                    waitrequest,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    protocol_error
);

    localparam int c_BYTES  = DATA_WIDTH / 8;
    localparam int c_DEPTH  = 2 ** ADDR_WIDTH;
    localparam int c_WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int c_PEND_W = $clog2(MAX_PENDING + 1);
    localparam logic [c_WCNT_W-1:0] c_WAIT_MAX = c_WCNT_W'(WAIT_CYCLES);
    localparam logic [c_PEND_W-1:0] c_PEND_MAX = c_PEND_W'(MAX_PENDING);

    logic [DATA_WIDTH-1:0]   r_mem [c_DEPTH];
    logic [c_PEND_W-1:0]     r_pend;
    logic [READ_LATENCY-1:0] r_vld;
    logic [DATA_WIDTH-1:0]   r_dat [READ_LATENCY];
    logic                    r_perr;

    logic w_req;
    logic w_illegal;
    logic w_wait_busy;
    logic w_accept;
    logic w_rd_accept;
    logic w_wr_accept;
    logic w_ret;

    assign w_req       = chipselect & (read ^ write);
    assign w_illegal   = chipselect & read & write;
    assign waitrequest = w_wait_busy | (read & (r_pend == c_PEND_MAX));
    assign w_accept    = w_req & ~waitrequest;
    assign w_rd_accept = w_accept & read;
    assign w_wr_accept = w_accept & write;
    assign w_ret       = r_vld[READ_LATENCY-1];

    // Wait-state counter only exists when wait states are configured.
    generate
        if (WAIT_CYCLES == 0) begin : g_zero_wait
            assign w_wait_busy = 1'b0;
        end else begin : g_wait_cnt
            logic [c_WCNT_W-1:0] r_wcnt;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_wcnt <= '0;
                end else if (!w_req || w_accept) begin
                    r_wcnt <= '0;
                end else if (r_wcnt != c_WAIT_MAX) begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
            end

            assign w_wait_busy = (r_wcnt < c_WAIT_MAX);
        end
    endgenerate

    // Outstanding reads: an accept and a return in the same cycle cancel.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '0;
        end else begin
            case ({w_rd_accept, w_ret})
                2'b10:   r_pend <= r_pend + 1'b1;
                2'b01:   r_pend <= r_pend - 1'b1;
                default: r_pend <= r_pend;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_rd_accept;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    // Data stages carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clock) begin
        if (w_rd_accept) begin
            r_dat[0] <= r_mem[address];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            r_dat[i] <= r_dat[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_illegal;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clock) begin
        if (w_wr_accept) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (byteenable[b]) begin
                    r_mem[address][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    assign readdatavalid  = w_ret;
    assign readdata       = w_ret ? r_dat[READ_LATENCY-1] : '0;
    assign protocol_error = r_perr;

endmodule
`default_nettype wire

// File: tb/tb_avalon_mem_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_mem_model
// Description : Directed scoreboard bench over three configurations of the
//               Avalon-MM memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_mem_model;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          lat [3] = '{2, 3, 2};

    logic        cs [3];
    logic        rd [3];
    logic        wr [3];
    logic [15:0] ad [3];
    logic [3:0]  be [3];
    logic [31:0] wd [3];

    logic        wq [3];
    logic        rv [3];
    logic        pe [3];
    logic [31:0] rdat [3];

    logic        wq_a, rv_a, pe_a, wq_b, rv_b, pe_b, wq_c, rv_c, pe_c;
    logic [31:0] rdat_a, rdat_b;
    logic [15:0] rdat_c;

    exp_t sb0 [$];
    exp_t sb1 [$];
    exp_t sb2 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    avalon_mem_model #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .WAIT_CYCLES(1),
                       .READ_LATENCY(2), .MAX_PENDING(4), .INIT_FILE("")) dut_a (
        .clock(clk), .reset_n(reset_n), .address(ad[0]), .chipselect(cs[0]),
        .read(rd[0]), .write(wr[0]), .byteenable(be[0]), .writedata(wd[0]),
        .waitrequest(wq_a), .readdata(rdat_a), .readdatavalid(rv_a),
        .protocol_error(pe_a));

    avalon_mem_model #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_CYCLES(0),
                       .READ_LATENCY(3), .MAX_PENDING(2), .INIT_FILE("")) dut_b (
        .clock(clk), .reset_n(reset_n), .address(ad[1][7:0]), .chipselect(cs[1]),
        .read(rd[1]), .write(wr[1]), .byteenable(be[1]), .writedata(wd[1]),
        .waitrequest(wq_b), .readdata(rdat_b), .readdatavalid(rv_b),
        .protocol_error(pe_b));

    avalon_mem_model #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_CYCLES(1),
                       .READ_LATENCY(2), .MAX_PENDING(4), .INIT_FILE("")) dut_c (
        .clock(clk), .reset_n(reset_n), .address(ad[2][7:0]), .chipselect(cs[2]),
        .read(rd[2]), .write(wr[2]), .byteenable(be[2][1:0]), .writedata(wd[2][15:0]),
        .waitrequest(wq_c), .readdata(rdat_c), .readdatavalid(rv_c),
        .protocol_error(pe_c));

    assign wq[0] = wq_a;  assign rv[0] = rv_a;  assign pe[0] = pe_a;  assign rdat[0] = rdat_a;
    assign wq[1] = wq_b;  assign rv[1] = rv_b;  assign pe[1] = pe_b;  assign rdat[1] = rdat_b;
    assign wq[2] = wq_c;  assign rv[2] = rv_c;  assign pe[2] = pe_c;  assign rdat[2] = {16'h0, rdat_c};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int i, input logic [31:0] d, input int due);
        exp_t e;
        e.data = d;
        e.due  = due;
        case (i)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    task automatic check_ret(input int i);
        exp_t e;
        int   sz;
        case (i)
            0:       sz = sb0.size();
            1:       sz = sb1.size();
            default: sz = sb2.size();
        endcase
        chk($sformatf("valid_expected_i%0d", i), 64'(sz > 0), 64'd1);
        if (sz > 0) begin
            case (i)
                0:       e = sb0.pop_front();
                1:       e = sb1.pop_front();
                default: e = sb2.pop_front();
            endcase
            chk($sformatf("rdata_i%0d", i), 64'(rdat[i]), 64'(e.data));
            chk($sformatf("rvalid_cycle_i%0d", i), 64'(cyc), 64'(e.due));
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rv[i] === 1'b1) check_ret(i);
        end
    end

    // Holds the command until accepted; leaves inputs driven just after the accept edge.
    task automatic cmd(input int i, input bit r, input bit w, input logic [15:0] a,
                       input logic [3:0] b, input logic [31:0] d, input logic [31:0] exp,
                       input bit track, output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        cs[i] = 1'b1; rd[i] = r; wr[i] = w; ad[i] = a; be[i] = b; wd[i] = d;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (wq[i] === 1'b0) begin
                done = 1'b1;
                if (r && track) push_exp(i, exp, cyc + lat[i]);
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("cmd_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int i);
        cs[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int wv [4];
        for (int i = 0; i < 3; i++) begin
            idle(i);
            ad[i] = '0; be[i] = '0; wd[i] = '0;
        end
        reset_n = 1'b0;
        step(3);
        @(negedge clk);
        chk("rst_rvalid", 64'(rv[0]), 64'd0);
        chk("rst_rdata",  64'(rdat[0]), 64'd0);
        chk("rst_perr",   64'(pe[0]), 64'd0);
        chk("rst_wait_a", 64'(wq[0]), 64'd1);
        chk("rst_wait_b", 64'(wq[1]), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(1);

        // Full write, byte-0 overwrite, readback with one wait state each.
        cmd(0, 0, 1, 16'd5, 4'hF, 32'hDEADBEEF, 32'h0, 0, w);
        chk("t1_wr_full_waits", 64'(w), 64'd1);
        cmd(0, 0, 1, 16'd5, 4'h1, 32'h000000AA, 32'h0, 0, w);
        chk("t1_wr_byte_waits", 64'(w), 64'd1);
        cmd(0, 1, 0, 16'd5, 4'h0, 32'h0, 32'hDEADBEAA, 1, w);
        chk("t1_rd_waits", 64'(w), 64'd1);
        idle(0);
        step(4);

        // Illegal read+write: no accept, one-cycle error pulse, memory intact.
        cmd(0, 0, 1, 16'd7, 4'hF, 32'h11223344, 32'h0, 0, w);
        idle(0);
        step(1);
        cs[0] = 1'b1; rd[0] = 1'b1; wr[0] = 1'b1; ad[0] = 16'd7; wd[0] = 32'hFFFFFFFF;
        step(1);
        idle(0);
        @(negedge clk);
        chk("t3_perr_pulse", 64'(pe[0]), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_perr_clear", 64'(pe[0]), 64'd0);
        chk("t3_rdata_idle", 64'(rdat[0]), 64'd0);
        @(posedge clk); #1;
        cmd(0, 1, 0, 16'd7, 4'h0, 32'h0, 32'h11223344, 1, w);
        idle(0);
        step(4);

        // 16-bit instance: upper-lane write merges with existing low byte.
        cmd(2, 0, 1, 16'd0, 4'b0011, 32'h1234, 32'h0, 0, w);
        cmd(2, 0, 1, 16'd0, 4'b0010, 32'hAB00, 32'h0, 0, w);
        cmd(2, 1, 0, 16'd0, 4'b0000, 32'h0, 32'hAB34, 1, w);
        idle(2);
        step(4);

        // Pending-limit throttling on the zero-wait instance.
        for (int k = 0; k < 4; k++) cmd(1, 0, 1, 16'(k), 4'hF, 32'h10 + 32'(k), 32'h0, 0, w);
        for (int k = 0; k < 4; k++) cmd(1, 1, 0, 16'(k), 4'h0, 32'h0, 32'h10 + 32'(k), 1, wv[k]);
        idle(1);
        chk("t2_wait_r0", 64'(wv[0]), 64'd0);
        chk("t2_wait_r1", 64'(wv[1]), 64'd0);
        chk("t2_wait_r2", 64'(wv[2]), 64'd2);
        chk("t2_wait_r3", 64'(wv[3]), 64'd0);
        step(6);

        // Write then immediately read the same word.
        cmd(1, 0, 1, 16'd9, 4'hF, 32'h55, 32'h0, 0, w);
        cmd(1, 1, 0, 16'd9, 4'h0, 32'h0, 32'h55, 1, w);
        chk("t4_rd_waits", 64'(w), 64'd0);
        idle(1);
        step(6);

        // Reset with two reads in flight: neither may return; memory survives.
        cmd(1, 1, 0, 16'd0, 4'h0, 32'h0, 32'h0, 0, w);
        cmd(1, 1, 0, 16'd1, 4'h0, 32'h0, 32'h0, 0, w);
        idle(1);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        @(negedge clk);
        chk("t5_pend_cleared", 64'(dut_b.r_pend), 64'd0);
        chk("t5_no_rvalid", 64'(rv[1]), 64'd0);
        step(6);
        cmd(1, 1, 0, 16'd0, 4'h0, 32'h0, 32'h10, 1, w);
        idle(1);
        cmd(0, 1, 0, 16'd5, 4'h0, 32'h0, 32'hDEADBEAA, 1, w);
        idle(0);

        for (int k = 0; k < 20 && (sb0.size() + sb1.size() + sb2.size()) > 0; k++) step(1);
        chk("drain_all_returned", 64'(sb0.size() + sb1.size() + sb2.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
